// File: rtl/traffic_pkg.sv
// Lamp and phase encodings, fault codes and monitor state shared by the
// intersection controller and its independent light-sequence monitor.
package traffic_pkg;

   localparam logic [2:0] LAMP_G = 3'b001;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_R = 3'b100;

   localparam logic [2:0] PH_S1      = 3'd0;
   localparam logic [2:0] PH_S2      = 3'd1;
   localparam logic [2:0] PH_S3      = 3'd2;
   localparam logic [2:0] PH_S4      = 3'd3;
   localparam logic [2:0] PH_S5      = 3'd4;
   localparam logic [2:0] PH_S6      = 3'd5;
   localparam logic [2:0] PH_INVALID = 3'd7;

   // Lamp patterns packed as {M1, M2, MT, S}
   localparam logic [11:0] PAT_S1 = {LAMP_G, LAMP_G, LAMP_R, LAMP_R};
   localparam logic [11:0] PAT_S2 = {LAMP_G, LAMP_Y, LAMP_R, LAMP_R};
   localparam logic [11:0] PAT_S3 = {LAMP_G, LAMP_R, LAMP_G, LAMP_R};
   localparam logic [11:0] PAT_S4 = {LAMP_Y, LAMP_R, LAMP_Y, LAMP_R};
   localparam logic [11:0] PAT_S5 = {LAMP_R, LAMP_R, LAMP_R, LAMP_G};
   localparam logic [11:0] PAT_S6 = {LAMP_R, LAMP_R, LAMP_R, LAMP_Y};

   localparam logic [2:0] FLT_NONE        = 3'd0;
   localparam logic [2:0] FLT_CONFLICT    = 3'd1;
   localparam logic [2:0] FLT_ENCODING    = 3'd2;
   localparam logic [2:0] FLT_SEQUENCE    = 3'd3;
   localparam logic [2:0] FLT_DWELL_SHORT = 3'd4;
   localparam logic [2:0] FLT_DWELL_LONG  = 3'd5;

   localparam int DEF_DWELL_S1 = 8;
   localparam int DEF_DWELL_S2 = 3;
   localparam int DEF_DWELL_S3 = 6;
   localparam int DEF_DWELL_S4 = 4;
   localparam int DEF_DWELL_S5 = 4;
   localparam int DEF_DWELL_S6 = 3;

   typedef enum logic [1:0] {
      MON_TRACK = 2'd0,
      MON_SYNC  = 2'd1,
      MON_FAULT = 2'd2
   } mon_state_t;

   function automatic logic [2:0] next_phase(input logic [2:0] ph);
      logic [2:0] nxt;
      nxt = (ph == PH_S6) ? PH_S1 : ph + 3'd1;
      return nxt;
   endfunction

   function automatic logic is_lamp(input logic [2:0] lamp);
      logic ok;
      ok = (lamp == LAMP_G) || (lamp == LAMP_Y) || (lamp == LAMP_R);
      return ok;
   endfunction

endpackage

// File: rtl/traffic_phase_decode.sv
// Combinational map from the four lamp buses to {phase, conflict, bad_encoding};
// also usable as a reference model for the controller.
module traffic_phase_decode
   import traffic_pkg::*;
(
   input  logic [2:0] light_M1,
   input  logic [2:0] light_M2,
   input  logic [2:0] light_MT,
   input  logic [2:0] light_S,
   output logic [2:0] phase,
   output logic       conflict,
   output logic       bad_encoding
);

   logic [2:0] lamp [4];
   logic [3:0] legal;
   logic [3:0] lit;

   assign lamp[0] = light_M1;
   assign lamp[1] = light_M2;
   assign lamp[2] = light_MT;
   assign lamp[3] = light_S;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lamp
         assign legal[gi] = is_lamp(lamp[gi]);
         assign lit[gi]   = (lamp[gi] != LAMP_R);
      end
   endgenerate

   // Side road against everything, and the turn lane against oncoming main road 2
   assign conflict = (lit[3] & (lit[0] | lit[1] | lit[2])) | (lit[2] & lit[1]);

   always_comb begin
      phase = PH_INVALID;
      case ({light_M1, light_M2, light_MT, light_S})
         PAT_S1:  phase = PH_S1;
         PAT_S2:  phase = PH_S2;
         PAT_S3:  phase = PH_S3;
         PAT_S4:  phase = PH_S4;
         PAT_S5:  phase = PH_S5;
         PAT_S6:  phase = PH_S6;
         default: phase = PH_INVALID;
      endcase
   end

   assign bad_encoding = ~(&legal) | (phase == PH_INVALID);

endmodule

// File: rtl/traffic_light_monitor.sv
// Two-stage conflict/sequence/dwell monitor for the intersection light buses;
// latches the first fault and counts completed light cycles.
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int DWELL_S1 = DEF_DWELL_S1,
   parameter int DWELL_S2 = DEF_DWELL_S2,
   parameter int DWELL_S3 = DEF_DWELL_S3,
   parameter int DWELL_S4 = DEF_DWELL_S4,
   parameter int DWELL_S5 = DEF_DWELL_S5,
   parameter int DWELL_S6 = DEF_DWELL_S6,
   parameter int CNT_W    = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       light_M1,
   input  logic [2:0]       light_M2,
   input  logic [2:0]       light_MT,
   input  logic [2:0]       light_S,
   input  logic             clr_fault,
   output logic [2:0]       phase,
   output logic             in_sync,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic [2:0]       fault_phase,
   output logic             cycle_done,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam logic [3:0] DWELL_MAX = 4'd15;

   logic [2:0]       bus_in  [4];
   logic [2:0]       bus_reg [4];
   logic             clr_reg;
   logic             vld_reg;
   logic             first_reg;

   logic [2:0]       dec_phase;
   logic             dec_conflict;
   logic             dec_bad;

   mon_state_t       state_reg;
   logic [2:0]       phase_reg;
   logic [3:0]       dwell_reg;
   logic             sync_reg;
   logic             fault_reg;
   logic [2:0]       code_reg;
   logic [2:0]       fph_reg;
   logic             done_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic [2:0]       det_code;
   logic [3:0]       dwell_next;
   logic [3:0]       dwell_need;
   logic             same_phase;
   logic             legal_step;
   logic             wrap;

   function automatic logic [3:0] dwell_req(input logic [2:0] ph);
      logic [3:0] req;
      case (ph)
         PH_S1:   req = 4'(DWELL_S1);
         PH_S2:   req = 4'(DWELL_S2);
         PH_S3:   req = 4'(DWELL_S3);
         PH_S4:   req = 4'(DWELL_S4);
         PH_S5:   req = 4'(DWELL_S5);
         PH_S6:   req = 4'(DWELL_S6);
         default: req = DWELL_MAX;
      endcase
      return req;
   endfunction

   assign bus_in[0] = light_M1;
   assign bus_in[1] = light_M2;
   assign bus_in[2] = light_MT;
   assign bus_in[3] = light_S;

   // Stage 1 reset value mirrors the controller's reset phase
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_stage1
         always_ff @(posedge clk) begin
            if (rst) begin
               bus_reg[gi] <= PAT_S1[11-3*gi -: 3];
            end else begin
               bus_reg[gi] <= bus_in[gi];
            end
         end
      end
   endgenerate

   // The clear travels with the bus sample so both are judged on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_reg <= 1'b0;
         vld_reg <= 1'b0;
      end else begin
         clr_reg <= clr_fault;
         vld_reg <= 1'b1;
      end
   end

   traffic_phase_decode u_decode (
      .light_M1     (bus_reg[0]),
      .light_M2     (bus_reg[1]),
      .light_MT     (bus_reg[2]),
      .light_S      (bus_reg[3]),
      .phase        (dec_phase),
      .conflict     (dec_conflict),
      .bad_encoding (dec_bad)
   );

   always_comb begin
      same_phase = (dec_phase == phase_reg);
      legal_step = (dec_phase == next_phase(phase_reg));
      dwell_need = dwell_req(phase_reg);
      wrap       = vld_reg && (phase_reg == PH_S6) && (dec_phase == PH_S1);
      det_code   = FLT_NONE;

      if (vld_reg) begin
         if (dec_conflict) begin
            det_code = FLT_CONFLICT;
         end else if (dec_bad) begin
            det_code = FLT_ENCODING;
         end else if (state_reg == MON_TRACK) begin
            if (!same_phase) begin
               if (!legal_step) begin
                  det_code = FLT_SEQUENCE;
               end else if (dwell_reg < dwell_need) begin
                  det_code = FLT_DWELL_SHORT;
               end
            end else if (!first_reg && (dwell_reg == dwell_need)) begin
               det_code = FLT_DWELL_LONG;
            end
         end
      end

      // The reset dwell of 1 already stands for the first sampled cycle
      if (same_phase && !first_reg) begin
         dwell_next = (dwell_reg == DWELL_MAX) ? DWELL_MAX : dwell_reg + 4'd1;
      end else begin
         dwell_next = 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= MON_TRACK;
         phase_reg <= PH_S1;
         dwell_reg <= 4'd1;
         first_reg <= 1'b1;
         sync_reg  <= 1'b1;
         fault_reg <= 1'b0;
         code_reg  <= FLT_NONE;
         fph_reg   <= PH_S1;
         done_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         done_reg <= 1'b0;
         if (vld_reg) begin
            phase_reg <= dec_phase;
            dwell_reg <= dwell_next;
            first_reg <= 1'b0;
         end

         if ((det_code != FLT_NONE) && ((state_reg != MON_FAULT) || clr_reg)) begin
            state_reg <= MON_FAULT;
            sync_reg  <= 1'b0;
            fault_reg <= 1'b1;
            code_reg  <= det_code;
            fph_reg   <= phase_reg;
         end else if (clr_reg) begin
            state_reg <= MON_SYNC;
            sync_reg  <= 1'b0;
            fault_reg <= 1'b0;
            code_reg  <= FLT_NONE;
            fph_reg   <= PH_S1;
         end else begin
            case (state_reg)
               MON_SYNC: begin
                  if (wrap) begin
                     state_reg <= MON_TRACK;
                     sync_reg  <= 1'b1;
                  end
               end
               MON_TRACK: begin
                  if (wrap) begin
                     done_reg <= 1'b1;
                     if (cnt_reg != {CNT_W{1'b1}}) begin
                        cnt_reg <= cnt_reg + 1'b1;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign phase       = phase_reg;
   assign in_sync     = sync_reg;
   assign fault       = fault_reg;
   assign fault_code  = code_reg;
   assign fault_phase = fph_reg;
   assign cycle_done  = done_reg;
   assign cycle_cnt   = cnt_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: each driven cycle pushes its expected
// outputs, which are popped and compared two edges later.
module tb_traffic_light_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  light_M1;
   logic [2:0]  light_M2;
   logic [2:0]  light_MT;
   logic [2:0]  light_S;
   logic        clr_fault;
   logic [2:0]  phase;
   logic        in_sync;
   logic        fault;
   logic [2:0]  fault_code;
   logic [2:0]  fault_phase;
   logic        cycle_done;
   logic [15:0] cycle_cnt;

   traffic_light_monitor #(
      .DWELL_S1 (8),
      .DWELL_S2 (3),
      .DWELL_S3 (6),
      .DWELL_S4 (4),
      .DWELL_S5 (4),
      .DWELL_S6 (3),
      .CNT_W    (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .light_M1    (light_M1),
      .light_M2    (light_M2),
      .light_MT    (light_MT),
      .light_S     (light_S),
      .clr_fault   (clr_fault),
      .phase       (phase),
      .in_sync     (in_sync),
      .fault       (fault),
      .fault_code  (fault_code),
      .fault_phase (fault_phase),
      .cycle_done  (cycle_done),
      .cycle_cnt   (cycle_cnt)
   );

   always #5 clk = ~clk;

   // Patterns as {M1, M2, MT, S}; G=001 Y=010 R=100
   localparam logic [11:0] P0   = {3'b001, 3'b001, 3'b100, 3'b100};
   localparam logic [11:0] P1   = {3'b001, 3'b010, 3'b100, 3'b100};
   localparam logic [11:0] P2   = {3'b001, 3'b100, 3'b001, 3'b100};
   localparam logic [11:0] P3   = {3'b010, 3'b100, 3'b010, 3'b100};
   localparam logic [11:0] P4   = {3'b100, 3'b100, 3'b100, 3'b001};
   localparam logic [11:0] P5   = {3'b100, 3'b100, 3'b100, 3'b010};
   localparam logic [11:0] PC   = {3'b001, 3'b100, 3'b100, 3'b001};
   localparam logic [11:0] PBAD = {3'b001, 3'b011, 3'b100, 3'b100};

   typedef struct {
      int          due;
      logic [2:0]  ph;
      logic        flt;
      logic [2:0]  code;
      logic [2:0]  fph;
      logic        sync;
      logic        done;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb [$];
   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;

   logic        e_flt;
   logic [2:0]  e_code;
   logic [2:0]  e_fph;
   logic        e_sync;
   logic [15:0] e_cnt;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic advance();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         $display("cyc %0d phase=%0d fault=%0b code=%0d fphase=%0d in_sync=%0b done=%0b cnt=%0d",
                  cyc, phase, fault, fault_code, fault_phase, in_sync, cycle_done, cycle_cnt);
         chk("phase",       {13'd0, phase},       {13'd0, e.ph});
         chk("fault",       {15'd0, fault},       {15'd0, e.flt});
         chk("fault_code",  {13'd0, fault_code},  {13'd0, e.code});
         chk("fault_phase", {13'd0, fault_phase}, {13'd0, e.fph});
         chk("in_sync",     {15'd0, in_sync},     {15'd0, e.sync});
         chk("cycle_done",  {15'd0, cycle_done},  {15'd0, e.done});
         chk("cycle_cnt",   cycle_cnt,            e.cnt);
      end
   endtask

   task automatic step(input logic [11:0] pat, input logic clr, input logic [2:0] ph, input logic done);
      exp_t e;
      {light_M1, light_M2, light_MT, light_S} = pat;
      clr_fault = clr;
      e.due  = cyc + 2;
      e.ph   = ph;
      e.flt  = e_flt;
      e.code = e_code;
      e.fph  = e_fph;
      e.sync = e_sync;
      e.done = done;
      e.cnt  = e_cnt;
      sb.push_back(e);
      advance();
   endtask

   task automatic run(input logic [11:0] pat, input logic [2:0] ph, input int n);
      for (int i = 0; i < n; i++) step(pat, 1'b0, ph, 1'b0);
   endtask

   task automatic reset_chk(input logic [11:0] pat, input logic clr);
      rst = 1'b1;
      clr_fault = clr;
      {light_M1, light_M2, light_MT, light_S} = pat;
      @(posedge clk);
      #1;
      cyc++;
      sb.delete();
      chk("rst_phase",       {13'd0, phase},       16'd0);
      chk("rst_in_sync",     {15'd0, in_sync},     16'd1);
      chk("rst_fault",       {15'd0, fault},       16'd0);
      chk("rst_fault_code",  {13'd0, fault_code},  16'd0);
      chk("rst_fault_phase", {13'd0, fault_phase}, 16'd0);
      chk("rst_cycle_done",  {15'd0, cycle_done},  16'd0);
      chk("rst_cycle_cnt",   cycle_cnt,            16'd0);
      rst = 1'b0;
      e_flt = 1'b0; e_code = 3'd0; e_fph = 3'd0; e_sync = 1'b1; e_cnt = 16'd0;
   endtask

   task automatic loop_once(input logic wrap_done);
      int          dw   [6] = '{8, 3, 6, 4, 4, 3};
      logic [11:0] pats [6] = '{P0, P1, P2, P3, P4, P5};
      logic        d;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < dw[k]; i++) begin
            d = (k == 0 && i == 0) ? wrap_done : 1'b0;
            if (d) e_cnt++;
            step(pats[k], 1'b0, 3'(k), d);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      clr_fault = 1'b0;
      {light_M1, light_M2, light_MT, light_S} = P0;
      reset_chk(P0, 1'b0);

      // Two nominal loops, second 5->0 at the start of the phase-0 hold
      loop_once(1'b0);
      loop_once(1'b1);
      e_cnt++;
      step(P0, 1'b0, 3'd0, 1'b1);
      run(P0, 3'd0, 7);
      e_flt = 1'b1; e_code = 3'd5; e_fph = 3'd0; e_sync = 1'b0;
      step(P0, 1'b0, 3'd0, 1'b0);

      // Clear: short phase 3 in SYNC is tolerated, 5->0 resyncs, then skip phase 1
      e_flt = 1'b0; e_code = 3'd0; e_fph = 3'd0;
      step(P0, 1'b1, 3'd0, 1'b0);
      run(P3, 3'd3, 2);
      run(P4, 3'd4, 4);
      run(P5, 3'd5, 3);
      e_sync = 1'b1;
      run(P0, 3'd0, 8);
      e_flt = 1'b1; e_code = 3'd3; e_fph = 3'd0; e_sync = 1'b0;
      step(P2, 1'b0, 3'd2, 1'b0);
      step(PC, 1'b0, 3'd7, 1'b0);

      // Conflict right after clear, then a bad encoding after another clear
      e_flt = 1'b0; e_code = 3'd0;
      step(P0, 1'b1, 3'd0, 1'b0);
      e_flt = 1'b1; e_code = 3'd1; e_fph = 3'd0;
      step(PC, 1'b0, 3'd7, 1'b0);
      e_flt = 1'b0; e_code = 3'd0;
      step(P0, 1'b1, 3'd0, 1'b0);
      e_flt = 1'b1; e_code = 3'd2; e_fph = 3'd0;
      step(PBAD, 1'b0, 3'd7, 1'b0);

      // Resync, then a two-cycle phase 1 is short
      e_flt = 1'b0; e_code = 3'd0; e_fph = 3'd0;
      step(P0, 1'b1, 3'd0, 1'b0);
      run(P4, 3'd4, 1);
      run(P5, 3'd5, 1);
      e_sync = 1'b1;
      run(P0, 3'd0, 8);
      run(P1, 3'd1, 2);
      e_flt = 1'b1; e_code = 3'd4; e_fph = 3'd1; e_sync = 1'b0;
      step(P2, 1'b0, 3'd2, 1'b0);

      // Clear coincident with a conflict: the new detection is latched
      e_code = 3'd1; e_fph = 3'd2;
      step(PC, 1'b1, 3'd7, 1'b0);

      // Resync and run into phase 3, then reset mid-phase with hostile inputs
      e_flt = 1'b0; e_code = 3'd0; e_fph = 3'd0;
      step(P0, 1'b1, 3'd0, 1'b0);
      run(P5, 3'd5, 1);
      e_sync = 1'b1;
      run(P0, 3'd0, 8);
      run(P1, 3'd1, 3);
      run(P2, 3'd2, 6);
      run(P3, 3'd3, 2);
      reset_chk(PC, 1'b1);

      loop_once(1'b0);
      e_cnt++;
      step(P0, 1'b0, 3'd0, 1'b1);
      advance();
      advance();
      chk("scoreboard_drained", 16'(sb.size()), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Independent conflict/sequence monitor on the receiving end of the four light buses driven by the intersection controller (M1, M2, MT, S).
- Decodes each cycle's light pattern back into a phase number and checks for conflicting greens, illegal encodings, wrong phase order and wrong phase dwell.
- Latches the first fault for the safety supervisor and counts completed light cycles.

Parameters:
- DWELL_S1, 8, required cycles in phase 0 (M1 G, M2 G, MT R, S R)
- DWELL_S2, 3, required cycles in phase 1 (M1 G, M2 Y, MT R, S R)
- DWELL_S3, 6, required cycles in phase 2 (M1 G, M2 R, MT G, S R)
- DWELL_S4, 4, required cycles in phase 3 (M1 Y, M2 R, MT Y, S R)
- DWELL_S5, 4, required cycles in phase 4 (M1 R, M2 R, MT R, S G)
- DWELL_S6, 3, required cycles in phase 5 (M1 R, M2 R, MT R, S Y)
- CNT_W, 16, width of completed-cycle counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- light_M1  in  3  main road 1 lamp; 001=G, 010=Y, 100=R
- light_M2  in  3  main road 2 lamp, same encoding
- light_MT  in  3  main-turn lamp, same encoding
- light_S  in  3  side road lamp, same encoding
- clr_fault  in  1  clears latched fault, forces resync
- phase  out  3  decoded phase 0..5; 7 = no legal pattern
- in_sync  out  1  sequence/dwell checking active
- fault  out  1  latched fault
- fault_code  out  3  0 none, 1 conflict, 2 bad encoding, 3 sequence, 4 dwell short, 5 dwell long
- fault_phase  out  3  phase register value when fault latched
- cycle_done  out  1  one-cycle pulse on a correct 5->0 transition
- cycle_cnt  out  CNT_W  completed correct cycles, saturating

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: phase=0, in_sync=1, fault=0, fault_code=0, fault_phase=0, cycle_done=0, cycle_cnt=0, dwell=1.
  - The controller shares rst and starts in phase 0.
  - The first post-reset cycle is therefore dwell cycle 1 of phase 0.
- Stage 1: the four buses are registered every cycle.
- Stage 2: decode/check on the registered copy; all outputs are registered.
  - An offending pattern present in cycle n appears on fault/fault_code at the end of cycle n+1 (2 edges).
- Conflict check (priority 1): S non-red with any of M1/M2/MT non-red, or MT non-red with M2 non-red. Active in every state.
- Encoding check (priority 2): any bus not one-hot, or an unlisted combination of legal values. phase=7. Active in every state.
- Dwell counter: 4 bits, saturating at 15. Increments while the decoded phase is unchanged; loads 1 on a phase change.
- FSM states:
  - TRACK:
    - A phase change to anything other than (old+1) mod 6 gives code 3.
    - A legal next phase with old dwell < DWELL_old gives code 4.
    - A phase still unchanged when dwell already equals DWELL_old gives code 5, raised on the first extra cycle.
    - A correct 5->0 change with correct dwell pulses cycle_done and increments cycle_cnt.
  - SYNC:
    - Sequence and dwell checks are suppressed; in_sync=0.
    - On an observed 5->0 change, go to TRACK with dwell=1.
  - FAULT:
    - fault=1; fault_code and fault_phase are frozen at the first fault.
    - Further faults are ignored; phase keeps decoding.
- Simultaneous faults: the lowest code number wins.
- clr_fault in any state: clears fault/fault_code/fault_phase and moves to SYNC.
  - If a fault is detected in the same cycle, detection wins: it latches the new fault and stays in FAULT.
- rst mid-operation returns everything to its reset values in the next cycle, regardless of other inputs.
- Phase 7 is never a legal successor and counts as an encoding fault.

Decomposition:
- Shared package traffic_pkg holds:
  - lamp constants LAMP_G/LAMP_Y/LAMP_R
  - phase encodings PH_S1..PH_S6 and PH_INVALID
  - fault code constants
  - monitor state enum
  - the default dwell values
- The controller is retrofitted to use the same lamp and phase constants.
- One sub-module: traffic_phase_decode. It is combinational and maps the four buses to {phase, conflict, bad_encoding}, so the controller bench can reuse it as a reference model.

Test Plan:
- Reset, then a nominal sequence for 2 loops (28 cycles each, dwell 8/3/6/4/4/3): fault=0 throughout, cycle_done pulses twice, cycle_cnt=2, phase follows 0..5 delayed 2 edges.
- Hold phase 0 for 9 cycles: at the 9th cycle's detection, fault=1, fault_code=5, fault_phase=0, cycle_cnt unchanged.
- Phase 0 for 8 cycles then drive the phase-2 pattern (skip phase 1): fault_code=3, fault_phase=0; a later conflict does not overwrite the code.
- Drive M1=001, S=001, M2=100, MT=100 in SYNC right after clr_fault: fault_code=1 despite in_sync=0. Drive M2=011 alone: fault_code=2, phase=7.
- Fault latched, assert clr_fault: fault=0, in_sync=0. A short phase 3 (2 cycles) is not flagged. After a 5->0 change in_sync=1, and a short phase 1 (2 cycles) gives fault_code=4.
- clr_fault coincident with a conflict gives fault=1, code=1. rst asserted mid-phase 3 gives all outputs at reset values one edge later, and the nominal sequence then passes.
